// File: rtl/dmi_arbiter.sv
// Two-requester round-robin arbiter in front of a single DMI target port.
// One transaction in flight; a response timeout and drain keep a wedged target from hanging a requester.
package DM;
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  DM::dmi_req_t [1:0]    req_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  output DM::dmi_resp_t         resp_o,
  output logic [1:0]            resp_valid_o,
  input  logic [1:0]            resp_ready_i,
  output DM::dmi_req_t          dmi_req_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  input  DM::dmi_resp_t         dmi_resp_i,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o
);
  localparam int unsigned CW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TLAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [1:0]  OP_RSVD   = 2'd3;
  localparam logic [1:0]  RESP_FAIL = 2'd2;
  localparam logic [1:0]  RESP_BUSY = 2'd3;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DELIVER, DRAIN} state_e;

  state_e         state_q, state_d;
  DM::dmi_req_t   req_q;
  DM::dmi_resp_t  resp_q;
  logic           owner_q, last_q, timed_out_q;
  logic [CW-1:0]  cnt_q;
  logic           win, grant, tmo, rsvd;

  // On a tie the requester that did not win last time gets the port.
  assign win   = (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];
  assign grant = (state_q == IDLE) && req_valid_i[win] && !rst_i;
  assign rsvd  = (req_i[win].op == OP_RSVD);
  // Fires on the cycle the counter steps onto TIMEOUT_CYCLES.
  assign tmo   = (TIMEOUT_CYCLES != 0) && (state_q == WAIT) && (cnt_q == TLAST[CW-1:0]);

  for (genvar g = 0; g < 2; g++) begin : g_port
    assign req_ready_o[g]  = grant && (win == 1'(g));
    assign resp_valid_o[g] = (state_q == DELIVER) && (owner_q == 1'(g));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = rsvd ? DELIVER : ISSUE;
      ISSUE:   if (dmi_req_ready_i) state_d = WAIT;
      WAIT:    if (dmi_resp_valid_i || tmo) state_d = DELIVER;
      DELIVER: if (resp_ready_i[owner_q]) state_d = timed_out_q ? DRAIN : IDLE;
      DRAIN:   if (dmi_resp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmi_req_valid_o  = 1'b0;
    dmi_req_o        = '0;
    dmi_resp_ready_o = 1'b0;
    resp_o           = '0;
    case (state_q)
      ISSUE: begin
        dmi_req_valid_o = 1'b1;
        dmi_req_o       = req_q;
      end
      WAIT, DRAIN: dmi_resp_ready_o = 1'b1;
      DELIVER:     resp_o = resp_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q       <= '0;
      resp_q      <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      timed_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant) begin
          req_q   <= req_i[win];
          owner_q <= win;
          last_q  <= win;
          if (rsvd) resp_q <= '{data: 32'h0, resp: RESP_FAIL};
        end
        ISSUE: if (dmi_req_ready_i) cnt_q <= '0;
        WAIT: begin
          // A real response beats a timeout landing in the same cycle.
          if (dmi_resp_valid_i) begin
            resp_q <= dmi_resp_i;
          end else begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (tmo) begin
              resp_q      <= '{data: 32'h0, resp: RESP_BUSY};
              timed_out_q <= 1'b1;
            end
          end
        end
        DRAIN: if (dmi_resp_valid_i) timed_out_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter: scoreboard of expected responses and forwarded requests,
// pushed at acceptance and popped at the matching handshake.
module tb_dmi_arbiter;
  import DM::*;

  logic           clk = 1'b0;
  logic           rst;
  dmi_req_t [1:0] req;
  logic [1:0]     req_valid, req_ready, resp_valid, resp_ready;
  dmi_resp_t      resp, dmi_resp;
  dmi_req_t       dmi_req;
  logic           dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;

  dmi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .resp_o(resp), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .dmi_req_o(dmi_req), .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
    .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        owner;
    dmi_resp_t r;
  } exp_t;

  exp_t     sb[$];
  dmi_req_t fq[$];
  int       gnt_q[$], gcyc_q[$];
  int       n_chk = 0, n_err = 0, cyc = 0;
  logic     tgt_auto = 1'b1, exp_tmo = 1'b0;

  function automatic logic [31:0] tgt_model(dmi_req_t r);
    return r.data ^ 32'hDEADBEEF;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes just before the edge, then play the target at the next negedge.
  task automatic step();
    logic     dreq_hs, dresp_hs;
    dmi_req_t r;
    exp_t     e;
    #1;
    dreq_hs  = dmi_req_valid && dmi_req_ready;
    dresp_hs = dmi_resp_valid && dmi_resp_ready;
    r        = dmi_req;
    if (dreq_hs) begin
      chk("fwd_pending", 64'(fq.size() > 0), 64'(1));
      if (fq.size() > 0) chk("fwd_req", 64'(r), 64'(fq.pop_front()));
    end
    if ((resp_valid & resp_ready) != 2'b00) begin
      chk("resp_pending", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_route", 64'(resp_valid), 64'(1) << e.owner);
        chk("resp_data", 64'(resp), 64'(e.r));
      end
    end
    if (!rst) for (int i = 0; i < 2; i++) if (req_valid[i] && req_ready[i]) begin
      gnt_q.push_back(i);
      gcyc_q.push_back(cyc);
      if (req[i].op != 2'd3) fq.push_back(req[i]);
      e.owner  = i;
      e.r.data = (req[i].op == 2'd3 || exp_tmo) ? 32'h0 : tgt_model(req[i]);
      e.r.resp = (req[i].op == 2'd3) ? 2'd2 : (exp_tmo ? 2'd3 : 2'd0);
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (tgt_auto) begin
      if (dresp_hs) dmi_resp_valid = 1'b0;
      if (dreq_hs) begin
        dmi_resp_valid = 1'b1;
        dmi_resp.data  = tgt_model(r);
        dmi_resp.resp  = 2'd0;
      end
    end
  endtask

  task automatic run(string tag, int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_ctrl"}, 64'({req_ready, resp_valid, dmi_req_valid, dmi_resp_ready}), 64'(0));
    chk({tag, "_resp"}, 64'(resp), 64'(0));
    chk({tag, "_dmi_req"}, 64'(dmi_req), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, viol;
    rst = 1'b1; req = '0; req_valid = 2'b00; resp_ready = 2'b11;
    dmi_req_ready = 1'b1; dmi_resp = '0; dmi_resp_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;

    // Single requester, zero-wait target
    req[0] = '{addr: 7'h11, op: 2'd1, data: 32'h0};
    req_valid = 2'b01; step(); req_valid = 2'b00;
    chk("single_issue_valid", 64'(dmi_req_valid), 64'(1));
    chk("single_issue_addr", 64'(dmi_req.addr), 64'(7'h11));
    run("single", 20);

    // Reserved op from requester 1
    req[1] = '{addr: 7'h05, op: 2'd3, data: 32'h1234};
    req_valid = 2'b10; step(); req_valid = 2'b00;
    chk("rsvd_route", 64'(resp_valid), 64'(2'b10));
    chk("rsvd_resp", 64'(resp.resp), 64'(2'd2));
    chk("rsvd_no_dmi", 64'(dmi_req_valid), 64'(0));
    run("rsvd", 5);
    chk("rsvd_no_dmi_after", 64'(dmi_req_valid), 64'(0));

    // Round-robin with both requesters held valid
    req[0] = '{addr: 7'h02, op: 2'd0, data: 32'h1111_0000};
    req[1] = '{addr: 7'h03, op: 2'd2, data: 32'h2222_0000};
    gnt_q.delete(); gcyc_q.delete();
    req_valid = 2'b11;
    for (int i = 0; i < 40 && gnt_q.size() < 4; i++) step();
    req_valid = 2'b00;
    chk("rr_count", 64'(gnt_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < gnt_q.size(); i++) chk($sformatf("rr_gnt%0d", i), 64'(gnt_q[i]), 64'(i % 2));
    for (int i = 1; i < 4 && i < gcyc_q.size(); i++) chk($sformatf("rr_gap%0d", i), 64'(gcyc_q[i] - gcyc_q[i-1]), 64'(4));
    run("rr", 20);

    // Backpressure on issue, then on delivery
    gnt_q.delete();
    dmi_req_ready = 1'b0;
    req[1] = '{addr: 7'h2A, op: 2'd2, data: 32'hCAFE_F00D};
    req_valid = 2'b10; step(); req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_stable", 64'(dmi_req), 64'(req[1]));
      chk("bp_no_accept", 64'(req_ready), 64'(0));
      step();
    end
    dmi_req_ready = 1'b1; resp_ready = 2'b01;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_resp_valid", 64'(resp_valid), 64'(2'b10));
      chk("bp_resp_stable", 64'(resp), 64'({tgt_model(req[1]), 2'b00}));
      chk("bp_no_accept2", 64'(req_ready), 64'(0));
      step();
    end
    resp_ready = 2'b11; step(); req_valid = 2'b00;
    chk("bp_gnts", 64'(gnt_q.size()), 64'(1));
    chk("bp_sb_empty", 64'(sb.size()), 64'(0));

    // Timeout on a silent target, then drain the late response
    tgt_auto = 1'b0; exp_tmo = 1'b1;
    req[0] = '{addr: 7'h40, op: 2'd1, data: 32'h0};
    req_valid = 2'b01; step(); req_valid = 2'b00;
    step();
    k = 0;
    while (k < 20 && resp_valid == 2'b00) begin
      step();
      k++;
    end
    chk("tmo_latency", 64'(k), 64'(8));
    chk("tmo_route", 64'(resp_valid), 64'(2'b01));
    chk("tmo_resp", 64'(resp), 64'({32'h0, 2'd3}));
    step();
    exp_tmo = 1'b0;
    chk("drain_ready", 64'(dmi_resp_ready), 64'(1));
    chk("drain_no_resp", 64'(resp_valid), 64'(0));
    req_valid = 2'b11; gnt_q.delete(); viol = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready != 2'b00 || dmi_resp_ready != 1'b1 || resp_valid != 2'b00) viol++;
      step();
    end
    chk("drain_hold", 64'(viol), 64'(0));
    chk("drain_no_gnt", 64'(gnt_q.size()), 64'(0));
    dmi_resp_valid = 1'b1; dmi_resp = '{data: 32'hBAD0_BAD0, resp: 2'd0};
    step();
    dmi_resp_valid = 1'b0;
    #1;
    chk("drain_idle_tie", 64'(req_ready), 64'(2'b10));
    chk("late_not_fwd", 64'(resp_valid), 64'(0));
    chk("drain_ready_low", 64'(dmi_resp_ready), 64'(0));
    req_valid = 2'b00;
    step();
    chk("late_not_fwd2", 64'(resp_valid), 64'(0));
    chk("tmo_sb_empty", 64'(sb.size()), 64'(0));

    // Reset while waiting for a response
    req[0] = '{addr: 7'h10, op: 2'd1, data: 32'h0};
    req_valid = 2'b01; step(); req_valid = 2'b00;
    step();
    chk("wait_resp_ready", 64'(dmi_resp_ready), 64'(1));
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    sb.delete(); fq.delete();
    step();
    rst = 1'b0; req_valid = 2'b11; tgt_auto = 1'b1; gnt_q.delete();
    #1;
    chk("post_rst_tie", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    chk("post_rst_gnt", 64'(gnt_q.size() > 0 ? gnt_q[0] : -1), 64'(0));
    run("post_rst", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Shares a single DMI target port (the debug module register file behind the DMI decoder) between two requesters: the JTAG DTM and a secondary host/debug-bridge port. Requesters are arbitrated round-robin; exactly one transaction is outstanding at a time. The block sequences each transaction through request issue, response wait and response delivery. A response timeout keeps a wedged target from hanging either requester.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for a downstream response. 0 disables the timeout.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  2×DM::dmi_req_t  per-requester request `{addr[6:0], op[1:0], data[31:0]}`. Index 0 is the JTAG DTM, index 1 is the host bridge.
- `req_valid_i`  in  2  per-requester request valid.
- `req_ready_o`  out  2  per-requester request accepted.
- `resp_o`  out  DM::dmi_resp_t  response `{data[31:0], resp[1:0]}`, shared by both requesters.
- `resp_valid_o`  out  2  per-requester response valid. At most one bit is set.
- `resp_ready_i`  in  2  per-requester response ready.
- `dmi_req_o`  out  DM::dmi_req_t  downstream request.
- `dmi_req_valid_o`  out  1  downstream request valid.
- `dmi_req_ready_i`  in  1  downstream request ready.
- `dmi_resp_i`  in  DM::dmi_resp_t  downstream response.
- `dmi_resp_valid_i`  in  1  downstream response valid.
- `dmi_resp_ready_o`  out  1  downstream response ready.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DELIVER, DRAIN. The state resets to IDLE.
- **IDLE arbitration:**
  - The winner is the only valid requester.
  - If both requesters are valid, the winner is the one not in `last_q`.
  - `last_q` resets to 1, so requester 0 wins the first tie.
  - `req_ready_o[winner]` is driven high combinationally. The other bit stays low.
- **Acceptance** (`req_valid_i[w] & req_ready_o[w]`):
  - The request is latched into `req_q`, with `owner_q`=w and `last_q`=w.
  - If `op`=3 (reserved), `resp_q`={data 0, resp 2} and the FSM goes to DELIVER without touching downstream.
  - Otherwise the FSM goes to ISSUE.
  - Ops 0, 1 and 2 are forwarded unchanged, including NOP.
- **ISSUE:** `dmi_req_valid_o`=1 and `dmi_req_o`=`req_q`. Held stable until `dmi_req_ready_i`, then the FSM goes to WAIT and the timeout counter clears.
- **WAIT:**
  - `dmi_resp_ready_o`=1.
  - On `dmi_resp_valid_i`, `resp_q`=`dmi_resp_i` and the FSM goes to DELIVER.
  - Otherwise the counter increments each cycle.
  - If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`, `resp_q`={0, resp 3 (busy)}, `timed_out_q`=1 and the FSM goes to DELIVER.
  - The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates; it never wraps.
- **DELIVER:**
  - `resp_valid_o[owner_q]`=1 and `resp_o`=`resp_q`, held until `resp_ready_i[owner_q]`.
  - When the response is accepted, the FSM goes to DRAIN if `timed_out_q`, else to IDLE.
- **DRAIN:**
  - `dmi_resp_ready_o`=1. The late downstream response is discarded on `dmi_resp_valid_i`, then the FSM goes to IDLE and `timed_out_q` clears.
  - No new request is accepted while draining.
- **Simultaneous events:**
  - A response and the timeout in the same WAIT cycle: the real response wins.
  - A requester dropping valid before acceptance is legal; arbitration re-evaluates every IDLE cycle.
  - `resp_ready_i` of the non-owner is ignored.
- **Reset mid-transaction:** everything returns to IDLE and the in-flight transaction is abandoned. The downstream side is reset by the same `rst_i`.

## Timing
- **Output reset values:** `req_ready_o`=0, `resp_valid_o`=0, `resp_o`=0, `dmi_req_valid_o`=0, `dmi_req_o`=0, `dmi_resp_ready_o`=0.
- Except for the IDLE `req_ready_o`, all outputs are decoded from registered state only. `req_ready_o` depends combinationally on `req_valid_i`.
- **Latency:**
  - Acceptance at cycle t gives `dmi_req_valid_o` at t+1.
  - A downstream response at cycle r gives `resp_valid_o` at r+1.
  - Responder delivery at cycle d returns the FSM to IDLE at d+1, and the next acceptance can happen in that cycle.
  - Minimum round trip with a zero-wait target is 4 cycles, acceptance to acceptance.
  - A reserved op responds at t+1.
- **Timeout:** an issue accepted at cycle i with no response gives a busy response at `resp_valid_o` at cycle i+1+`TIMEOUT_CYCLES`.

## Test plan
- **Single requester:** requester 0 sends op=1, addr=0x11, zero-wait target returning data 0xDEADBEEF, resp 0. Required: downstream sees addr 0x11 one cycle after acceptance; `resp_valid_o`=2'b01 with data 0xDEADBEEF, resp 0.
- **Round-robin:** both requesters held valid continuously for 4 transactions. Required grant order is 0,1,0,1, and `resp_valid_o` routes each response to its owner only.
- **Backpressure:** `dmi_req_ready_i` low for 5 cycles, then `resp_ready_i[1]` low for 3 cycles. Required: `dmi_req_o` and `resp_o` stay stable throughout, and no second request is accepted.
- **Timeout and drain:** `TIMEOUT_CYCLES`=8, target silent. Required: resp 3 delivered 9 cycles after issue. The late response injected 20 cycles later is consumed with `dmi_resp_ready_o`=1, never forwarded, and the FSM then returns to IDLE.
- **Reserved op:** op=3 from requester 1. Required: resp 2 on `resp_valid_o`=2'b10 one cycle later, and `dmi_req_valid_o` never asserts.
- **Reset mid-WAIT:** assert `rst_i` while in WAIT. Required: all outputs 0 immediately, and the first tie after reset goes to requester 0.
